// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the shared UART TX FIFO push port.
// Define UART_TX_ARB_HDR_EN to prefix every packet with SYNC_BYTE and the channel ID.
module uart_tx_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    N_REQ      = 2,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'hA5,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
  input  logic [N_REQ-1:0]              last_i,
  output logic [N_REQ-1:0]              ready_o,
  output logic [N_REQ-1:0]              gnt_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_push_data_o,
  output logic                          busy_o,
  output logic [$clog2(N_REQ)-1:0]      cur_ch_o,
  output logic                          timeout_err_o
);
  localparam int CW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE     = 2'd0;
`ifdef UART_TX_ARB_HDR_EN
  localparam logic [1:0] S_HDR_SYNC = 2'd1;
  localparam logic [1:0] S_HDR_ID   = 2'd2;
  localparam logic [1:0] S_FIRST    = S_HDR_SYNC;
`else
  localparam logic [1:0] S_FIRST    = 2'd3;
`endif
  localparam logic [1:0] S_STREAM   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [CW-1:0]         cur_q, cur_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic                  pick_ok;
  logic [CW-1:0]         pick_idx;
  logic [CW:0]           cand;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  push, pkt_end, wd_expire;

  assign g_valid = valid_i[cur_q];
  assign g_last  = last_i[cur_q];
  assign g_data  = data_i[cur_q*DATA_WIDTH +: DATA_WIDTH];

  // Walk from farthest to nearest so the channel right after rr_q is written last and wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, rr_q} + (CW+1)'(k);
      if (cand >= (CW+1)'(N_REQ)) cand = cand - (CW+1)'(N_REQ);
      if (req_i[cand[CW-1:0]]) begin
        pick_ok  = 1'b1;
        pick_idx = cand[CW-1:0];
      end
    end
  end

  always_comb begin
    ready_o          = '0;
    push             = 1'b0;
    fifo_push_data_o = '0;
    case (state_q)
`ifdef UART_TX_ARB_HDR_EN
      S_HDR_SYNC: begin
        push             = ~fifo_full_i;
        fifo_push_data_o = SYNC_BYTE;
      end
      S_HDR_ID: begin
        push             = ~fifo_full_i;
        fifo_push_data_o = DATA_WIDTH'(cur_q);
      end
`endif
      S_STREAM: begin
        ready_o[cur_q]   = ~fifo_full_i;
        push             = g_valid & ~fifo_full_i;
        fifo_push_data_o = g_data;
      end
      default: ;
    endcase
  end

  assign pkt_end = ((state_q == S_STREAM) && push && g_last) || wd_expire;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cur_d   = cur_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: if (pick_ok) begin
        gnt_d           = '0;
        gnt_d[pick_idx] = 1'b1;
        cur_d           = pick_idx;
        state_d         = S_FIRST;
      end
`ifdef UART_TX_ARB_HDR_EN
      S_HDR_SYNC: if (push) state_d = S_HDR_ID;
      S_HDR_ID:   if (push) state_d = S_STREAM;
`endif
      S_STREAM: ;
      default: state_d = S_IDLE;
    endcase
    // The released channel becomes the pointer, so it searches last next time.
    if (pkt_end) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      rr_d    = cur_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      cur_q   <= '0;
      rr_q    <= CW'(N_REQ-1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int WW = $clog2(TIMEOUT+1);
      logic [WW-1:0] wd_q, wd_d;
      // A transfer in the expiry cycle keeps the packet alive.
      assign wd_expire = (state_q != S_IDLE) && !push && (wd_q == WW'(TIMEOUT-1));
      assign wd_d = (state_q == S_IDLE || push || wd_expire) ? '0 : wd_q + WW'(1);
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) wd_q <= '0;
        else         wd_q <= wd_d;
      end
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  assign fifo_push_o   = push;
  assign gnt_o         = gnt_q;
  assign cur_ch_o      = cur_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = wd_expire;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single UART TX byte FIFO among `N_REQ` byte-stream requesters, such as the frame-buffer streamer and the command-response generator. It sits between the requesters and the TX FIFO push port. It locks the grant for a whole packet (terminated by `last`), optionally prefixes each packet with a sync/channel header, and releases stalled grants via a watchdog.

## Interface
- `DATA_WIDTH`, 8, byte width of every stream and of the FIFO push data.
- `N_REQ`, 2, number of requesters (≥2); channel index `i` is the requester's ID.
- `SYNC_BYTE`, 8'hA5, header sync byte (used only with the header feature).
- `TIMEOUT`, 1024, idle cycles allowed inside a granted packet before forced release; 0 disables the watchdog.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-channel packet request; level, sampled only in IDLE.
- `valid`  in  N_REQ  per-channel byte valid.
- `data`  in  N_REQ*DATA_WIDTH  per-channel byte; channel `i` at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `last`  in  N_REQ  marks the final byte of the packet; qualified by valid&ready.
- `ready`  out  N_REQ  per-channel byte accept.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `fifo_full`  in  1  TX FIFO full.
- `fifo_push`  out  1  TX FIFO push strobe.
- `fifo_push_data`  out  DATA_WIDTH  TX FIFO push data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `cur_ch`  out  $clog2(N_REQ)  index of the granted channel; holds the last value in IDLE.
- `timeout_err`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- States: IDLE, HDR_SYNC, HDR_ID, STREAM. The HDR states exist only with `UART_TX_ARB_HDR_EN`.
- IDLE, any `req` set: pick the first set `req` searching from `rr_ptr+1` upward, wrapping modulo N_REQ. Register `gnt` and `cur_ch`. Go to HDR_SYNC, or to STREAM without headers.
- IDLE, no `req` set: stay; all strobes are 0.
- HDR_SYNC: `fifo_push = ~fifo_full` and `fifo_push_data = SYNC_BYTE`. Advance on push.
- HDR_ID: same rule, with data = `cur_ch` zero-extended to DATA_WIDTH. Advance to STREAM on push.
- STREAM, combinational pass-through of the granted channel `g` only:
  - `ready[g] = ~fifo_full`, and `ready` of every other channel is 0.
  - `fifo_push = valid[g] & ~fifo_full` and `fifo_push_data = data[g]`.
- Transfer with `last[g]` set: go to IDLE, clear `gnt`, set `rr_ptr <= g`.
- Deasserting `req[g]` mid-packet is ignored; only `last` or the watchdog ends a packet.
- Watchdog: the counter clears on entry to STREAM and on every transfer, and increments otherwise in STREAM. On reaching TIMEOUT−1 without a transfer in that cycle:
  - go to IDLE and clear `gnt`;
  - pulse `timeout_err`;
  - set `rr_ptr <= g`, so the stalled channel loses priority.
- The watchdog also runs in HDR states, counting FIFO-full stalls.
- Counter width is $clog2(TIMEOUT+1). With `TIMEOUT`=0 no counter exists and `timeout_err` is tied to 0.
- A transfer and a watchdog expiry in the same cycle: the transfer wins, the counter clears, and there is no error.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, `rr_ptr` = N_REQ−1 so channel 0 wins first. All outputs are 0: `gnt`, `ready`, `fifo_push`, `fifo_push_data`, `busy`, `cur_ch`, `timeout_err`.
- Reset asserted mid-packet aborts the packet immediately. The downstream parser resyncs on SYNC_BYTE.
- Grant latency: `req` seen in IDLE at cycle N, so `gnt`/`busy` are high at N+1. The first byte or header can be pushed at N+1.
- STREAM throughput: one byte per cycle while `fifo_full`=0. Zero-cycle combinational path valid→push.
- Packet end: `last` accepted at cycle M, so `gnt` = 0 and state IDLE at M+1. The next grant is visible at M+2, giving a minimum one-cycle gap between packets.
- `fifo_full` high: no push and `ready[g]`=0. Data and headers hold until a push is accepted.

## Configuration
- `UART_TX_ARB_HDR_EN` defined: each packet is prefixed by 2 bytes, SYNC_BYTE then channel ID. Minimum packet cost is 3 pushes.
- Not defined: HDR states are removed, IDLE goes directly to STREAM, and the FIFO receives raw payload bytes only.

## Test plan
- Single channel 0, 4-byte packet (0x10..0x13, last on 0x13), FIFO never full, header on → pushes A5,00,10,11,12,13 in 6 consecutive cycles; `gnt`=01 from cycle 1; IDLE after.
- Both `req` high continuously, 2-byte packets → grants alternate ch0, ch1, ch0, … with one idle cycle between packets; no byte interleaving.
- `fifo_full` held high 5 cycles mid-packet → `ready[g]`=0 and `fifo_push`=0 for exactly those 5 cycles; no byte lost or duplicated.
- `TIMEOUT`=8, ch1 granted, then `valid[1]` stays low → `timeout_err` pulses once 8 cycles after the last transfer; `gnt`=0; ch0 granted next even with ch1 still requesting.
- Reset (low) asserted after the 2nd byte of a packet → all outputs 0 asynchronously; after release, ch0 is granted first.
- Header off, channel 1 sends 1-byte packet 0x7E with last → single push 0x7E, `busy` high for exactly 1 cycle.
